// File: rtl/pipeline_register_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer carrying {pc, instr, payload}.
// Define PIPE_STAT_EN to add the stall_cycles / flush_count statistics outputs.

`ifndef INVALID_INSTRUCTION
`define INVALID_INSTRUCTION 16'hDEAD
`endif

// state | meaning
// EMPTY | no entries held; main slot cleared
// ONE   | main slot valid, skid slot cleared
// FULL  | main and skid slots valid; in_ready low
module pipeline_register_stage #(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned PAYLOAD_WIDTH = 1,
  parameter logic [INSTR_WIDTH-1:0] INVALID_INSTR = `INVALID_INSTRUCTION
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
`ifdef PIPE_STAT_EN
  ,
  output logic [15:0]              stall_cycles,
  output logic [15:0]              flush_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    logic [INSTR_WIDTH-1:0]   instr;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  localparam entry_t CLEARED = '{pc: '0, instr: INVALID_INSTR, payload: '0};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;

  assign in_entry  = '{pc: in_pc, instr: in_instr, payload: in_payload};
  // in_ready comes straight off the state flops, so it is registered.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign out_pc      = main_q.pc;
  assign out_instr   = main_q.instr;
  assign out_payload = main_q.payload;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= CLEARED;
      skid_q  <= CLEARED;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Downstream still completes an out_xfer this cycle; any in_xfer is dropped.
      state_d = EMPTY;
      main_d  = CLEARED;
      skid_d  = CLEARED;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
            main_d  = CLEARED;
          end else if (in_xfer && out_xfer) begin
            main_d  = in_entry;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = CLEARED;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = CLEARED;
          skid_d  = CLEARED;
        end
      endcase
    end
  end

`ifdef PIPE_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_register_stage.sv
// Directed table-driven bench for pipeline_register_stage plus hand-written stall/drain sequence.
// Statistics checks are compiled in only when PIPE_STAT_EN is defined.
module tb_pipeline_register_stage;

  localparam logic [15:0] INV = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pc = '0;
  logic [15:0] in_instr = '0;
  logic [0:0]  in_payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [0:0]  out_payload;
`ifdef PIPE_STAT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipeline_register_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_payload (out_payload)
`ifdef PIPE_STAT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [15:0] pc;
    logic        ordy;
    logic        e_valid;
    logic        e_ready;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_pl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [15:0] pc, input logic ordy);
    reset      = rst;
    flush      = fl;
    in_valid   = iv;
    in_pc      = pc;
    in_instr   = 16'h1000 | pc;
    in_payload = pc[0];
    out_ready  = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected main-slot contents for an entry launched with pc p.
  function automatic vec_t row(input logic rst, input logic fl, input logic iv,
                               input logic [15:0] pc, input logic ordy,
                               input logic ev, input logic er, input logic [15:0] epc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.e_valid = ev; v.e_ready = er; v.e_pc = epc;
    v.e_instr = ev ? (16'h1000 | epc) : INV;
    v.e_pl    = ev ? epc[0] : 1'b0;
    return v;
  endfunction

  initial begin
    // reset
    vecs.push_back(row(1, 0, 0, 16'd0,  0, 0, 1, 16'd0));
    vecs.push_back(row(1, 0, 0, 16'd0,  0, 0, 1, 16'd0));
    // streaming at full rate
    vecs.push_back(row(0, 0, 1, 16'd0,  1, 1, 1, 16'd0));
    vecs.push_back(row(0, 0, 1, 16'd1,  1, 1, 1, 16'd1));
    vecs.push_back(row(0, 0, 1, 16'd2,  1, 1, 1, 16'd2));
    vecs.push_back(row(0, 0, 1, 16'd3,  1, 1, 1, 16'd3));
    vecs.push_back(row(0, 0, 0, 16'd0,  1, 0, 1, 16'd0));
    // backpressure: 10,11 absorbed, 12 held upstream
    vecs.push_back(row(0, 0, 1, 16'd10, 0, 1, 1, 16'd10));
    vecs.push_back(row(0, 0, 1, 16'd11, 0, 1, 0, 16'd10));
    vecs.push_back(row(0, 0, 1, 16'd12, 0, 1, 0, 16'd10));
    vecs.push_back(row(0, 0, 1, 16'd12, 1, 1, 1, 16'd11));
    vecs.push_back(row(0, 0, 1, 16'd12, 1, 1, 1, 16'd12));
    vecs.push_back(row(0, 0, 0, 16'd0,  1, 0, 1, 16'd0));
    // flush while FULL, pc 22 dropped
    vecs.push_back(row(0, 0, 1, 16'd20, 0, 1, 1, 16'd20));
    vecs.push_back(row(0, 0, 1, 16'd21, 0, 1, 0, 16'd20));
    vecs.push_back(row(0, 1, 1, 16'd22, 0, 0, 1, 16'd0));
    vecs.push_back(row(0, 0, 0, 16'd0,  0, 0, 1, 16'd0));
    // flush while ONE with an accepted input: input dropped
    vecs.push_back(row(0, 0, 1, 16'd31, 0, 1, 1, 16'd31));
    vecs.push_back(row(0, 1, 1, 16'd33, 0, 0, 1, 16'd0));
    vecs.push_back(row(0, 0, 0, 16'd0,  0, 0, 1, 16'd0));
    // reset with flush while FULL
    vecs.push_back(row(0, 0, 1, 16'd41, 0, 1, 1, 16'd41));
    vecs.push_back(row(0, 0, 1, 16'd43, 0, 1, 0, 16'd41));
    vecs.push_back(row(1, 1, 1, 16'd45, 1, 0, 1, 16'd0));
    vecs.push_back(row(0, 0, 0, 16'd0,  0, 0, 1, 16'd0));

    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      step();
      check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("v%0d out_pc", i), {16'd0, out_pc}, {16'd0, vecs[i].e_pc});
      check($sformatf("v%0d out_instr", i), {16'd0, out_instr}, {16'd0, vecs[i].e_instr});
      check($sformatf("v%0d out_payload", i), {31'd0, out_payload}, {31'd0, vecs[i].e_pl});
    end

    // Hold stability under a long stall, then ordered drain; also counts 5 stalls and 2 flushes.
    drive(1, 0, 0, 16'd0, 0);
    step();
    drive(0, 0, 1, 16'd51, 0);
    step();
    drive(0, 0, 1, 16'd52, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 16'd99 + 16'(k), 0);
      step();
      check($sformatf("stall%0d out_pc", k), {16'd0, out_pc}, 32'd51);
      check($sformatf("stall%0d out_instr", k), {16'd0, out_instr}, 32'h1033);
      check($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    drive(0, 0, 0, 16'd0, 1);
    step();
    check("drain0 out_pc", {16'd0, out_pc}, 32'd52);
    check("drain0 out_payload", {31'd0, out_payload}, 32'd0);
    step();
    check("drain1 out_valid", {31'd0, out_valid}, 32'd0);
    check("drain1 out_instr", {16'd0, out_instr}, {16'd0, INV});
    drive(0, 1, 0, 16'd0, 1);
    step();
    step();
    drive(0, 0, 0, 16'd0, 1);
    step();
    check("post flush in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_STAT_EN
    check("stall_cycles", {16'd0, stall_cycles}, 32'd5);
    check("flush_count", {16'd0, flush_count}, 32'd2);
    drive(1, 0, 0, 16'd0, 0);
    step();
    check("stall_cycles reset", {16'd0, stall_cycles}, 32'd0);
    check("flush_count reset", {16'd0, flush_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
